rx_to_mem: RTL and testbench



---
 rtl/rx_to_mem_pkg.sv | 22 ++
 rtl/rx_to_mem_if.sv | 9 +
 rtl/rx_to_mem_uart_rx_byte.sv | 87 ++++++++
 rtl/rx_to_mem.sv | 103 ++++++++++
 tb/tb_rx_to_mem.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_to_mem_pkg.sv
// rtl/rx_to_mem_pkg.sv - shared constants and state encodings for the UART-to-matrix loader
package rx_to_mem_pkg;

    // 9600 baud at 100 MHz; the transmit path's baud constant must match this value.
    localparam int CLKS_PER_BIT_DEFAULT = 10416;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_HI = 3'd1,
        WAIT_LO = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rx_to_mem_if.sv
// rtl/rx_to_mem_if.sv - matrix memory write port bundle
interface rx_to_mem_if;
    logic        write;
    logic [31:0] write_address;
    logic [15:0] write_value;

    modport master (output write, output write_address, output write_value);
    modport slave  (input  write, input  write_address, input  write_value);
endinterface

// File: rtl/rx_to_mem_uart_rx_byte.sv
// rtl/rx_to_mem_uart_rx_byte.sv - 8N1 UART byte sampler with start-bit glitch rejection
module uart_rx_byte
    import rx_to_mem_pkg::*;
#(
    parameter int clks_per_bit = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       frame_err
);

    localparam int CW = $clog2(clks_per_bit + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(clks_per_bit - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(clks_per_bit / 2 - 1);

    logic            sync1, sync2, rx_prev;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            sync1   <= rx_data;
            sync2   <= sync1;
            rx_prev <= sync2;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                // Edge, not level: a line held low after a bad stop bit must not start a frame.
                if (rx_prev && !sync2) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {sync2, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d      = '0;
                    state_d    = RX_IDLE;
                    byte_valid = sync2;
                    frame_err  = !sync2;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_out = shreg_q;

endmodule

// File: rtl/rx_to_mem.sv
// rtl/rx_to_mem.sv - pairs received UART bytes into 16-bit elements and writes them to matrix memory
module rx_to_mem
    import rx_to_mem_pkg::*;
#(
    parameter int row          = 2,
    parameter int column       = 2,
    parameter int clks_per_bit = CLKS_PER_BIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_data,
    input  logic            arm,
    rx_to_mem_if.master     mem,
    output logic            load_done,
    output logic            frame_err
);

    localparam int N = row * column;
    localparam logic [31:0] LAST_ADDR = 32'(N - 1);

    logic        byte_valid;
    logic [7:0]  byte_out;
    logic        arm_q, arm_qq, arm_rise;
    load_state_t state_q, state_d;
    logic [31:0] addr_q, addr_d, waddr_q, waddr_d;
    logic [15:0] value_q, value_d;

    uart_rx_byte #(.clks_per_bit(clks_per_bit)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .byte_valid (byte_valid),
        .byte_out   (byte_out),
        .frame_err  (frame_err)
    );

    assign arm_rise = arm_q & ~arm_qq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q   <= 1'b0;
            arm_qq  <= 1'b0;
            state_q <= IDLE;
            addr_q  <= '0;
            waddr_q <= '0;
            value_q <= '0;
        end else begin
            arm_q   <= arm;
            arm_qq  <= arm_q;
            state_q <= state_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        value_d = value_q;
        // Arm wins over a coincident byte; the in-flight sampler is left running.
        if (arm_rise) begin
            state_d = WAIT_HI;
            addr_d  = '0;
        end else begin
            case (state_q)
                WAIT_HI: begin
                    if (byte_valid) begin
                        value_d[15:8] = byte_out;
                        state_d       = WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (byte_valid) begin
                        value_d[7:0] = byte_out;
                        waddr_d      = addr_q;
                        state_d      = WRITE;
                    end else if (frame_err) begin
                        state_d = WAIT_HI;
                    end
                end
                WRITE: begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 32'd1;
                        state_d = WAIT_HI;
                    end
                end
                IDLE, DONE: state_d = state_q;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Address is latched on entry to WRITE so it holds steady between writes.
    assign mem.write         = (state_q == WRITE);
    assign mem.write_address = waddr_q;
    assign mem.write_value   = value_q;
    assign load_done         = (state_q == DONE);

endmodule

// File: tb/tb_rx_to_mem.sv
// tb/tb_rx_to_mem.sv - self-checking bench for rx_to_mem
module tb_rx_to_mem;

    localparam int CPB = 16;
    localparam int N   = 4;

    logic clk = 1'b0;
    logic rst;
    logic rx_data;
    logic arm;
    logic load_done;
    logic frame_err;

    rx_to_mem_if mem ();

    rx_to_mem #(.row(2), .column(2), .clks_per_bit(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .arm       (arm),
        .mem       (mem),
        .load_done (load_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wr_addr_q[$];
    logic [15:0] wr_val_q[$];
    int          ferr_cnt = 0;
    int          wide_cnt = 0;
    logic        wr_prev  = 1'b0;

    always @(negedge clk) begin
        if (mem.write === 1'b1) begin
            wr_addr_q.push_back(mem.write_address);
            wr_val_q.push_back(mem.write_value);
            if (wr_prev) wide_cnt++;
        end
        wr_prev = (mem.write === 1'b1);
        if (frame_err === 1'b1) ferr_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_data = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        if (!stop) drive_bit(1'b1);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        repeat (3) @(negedge clk);
        arm = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        bit          do_arm;
        logic [7:0]  b;
        bit          stop;
        bit          wr;
        logic [31:0] addr;
        logic [15:0] val;
        bit          done;
        bit          ferr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit a, input logic [7:0] b, input bit s, input bit w,
                       input logic [31:0] ad, input logic [15:0] v, input bit d, input bit f);
        vec_t e;
        e.do_arm = a; e.b = b; e.stop = s; e.wr = w;
        e.addr = ad; e.val = v; e.done = d; e.ferr = f;
        tbl.push_back(e);
    endtask

    initial begin
        int          n0, f0;
        int          m_addr;
        bit          m_hi_v, m_done;
        logic [7:0]  m_hi, rb;
        bit          rstop;
        logic [31:0] ex_a[$];
        logic [15:0] ex_v[$];

        rst = 1'b1; rx_data = 1'b1; arm = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_write", {31'd0, mem.write}, 0);
        chk("rst_addr", mem.write_address, 0);
        chk("rst_value", {16'd0, mem.write_value}, 0);
        chk("rst_done", {31'd0, load_done}, 0);
        chk("rst_ferr", {31'd0, frame_err}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_writes", wr_addr_q.size(), 0);
        chk("idle_done", {31'd0, load_done}, 0);

        // arm, byte, stop, write?, addr, value, load_done, frame_err
        add(0, 8'h11, 1, 0, 0, 16'h0000, 0, 0);
        add(0, 8'h22, 1, 0, 0, 16'h0000, 0, 0);
        add(1, 8'h12, 1, 0, 0, 16'h0000, 0, 0);
        add(0, 8'h34, 1, 1, 0, 16'h1234, 0, 0);
        add(0, 8'hAB, 1, 0, 0, 16'h0000, 0, 0);
        add(0, 8'hCD, 1, 1, 1, 16'hABCD, 0, 0);
        add(0, 8'h00, 1, 0, 0, 16'h0000, 0, 0);
        add(0, 8'h01, 1, 1, 2, 16'h0001, 0, 0);
        add(0, 8'hFF, 1, 0, 0, 16'h0000, 0, 0);
        add(0, 8'hFE, 1, 1, 3, 16'hFFFE, 1, 0);
        add(0, 8'h55, 1, 0, 0, 16'h0000, 1, 0);
        add(1, 8'h12, 1, 0, 0, 16'h0000, 0, 0);
        add(0, 8'h34, 0, 0, 0, 16'h0000, 0, 1);
        add(0, 8'h56, 1, 0, 0, 16'h0000, 0, 0);
        add(0, 8'h78, 1, 1, 0, 16'h5678, 0, 0);
        add(0, 8'h9A, 1, 0, 0, 16'h0000, 0, 0);
        add(0, 8'hBC, 1, 1, 1, 16'h9ABC, 0, 0);
        add(0, 8'h01, 1, 0, 0, 16'h0000, 0, 0);
        add(0, 8'h02, 1, 1, 2, 16'h0102, 0, 0);
        add(0, 8'h03, 1, 0, 0, 16'h0000, 0, 0);
        add(1, 8'hAA, 1, 0, 0, 16'h0000, 0, 0);
        add(0, 8'hBB, 1, 1, 0, 16'hAABB, 0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].do_arm) arm_pulse();
            n0 = wr_addr_q.size();
            f0 = ferr_cnt;
            send_byte(tbl[i].b, tbl[i].stop);
            chk($sformatf("tbl%0d_nwr", i), wr_addr_q.size() - n0, {31'd0, tbl[i].wr});
            if (tbl[i].wr && wr_addr_q.size() > n0) begin
                chk($sformatf("tbl%0d_addr", i), wr_addr_q[n0], tbl[i].addr);
                chk($sformatf("tbl%0d_val", i), {16'd0, wr_val_q[n0]}, {16'd0, tbl[i].val});
            end
            chk($sformatf("tbl%0d_done", i), {31'd0, load_done}, {31'd0, tbl[i].done});
            chk($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, {31'd0, tbl[i].ferr});
        end

        // Glitch while holding a high byte: must be invisible.
        send_byte(8'h77, 1'b1);
        n0 = wr_addr_q.size();
        f0 = ferr_cnt;
        rx_data = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx_data = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_nwr", wr_addr_q.size() - n0, 0);
        send_byte(8'h88, 1'b1);
        chk("glitch_after_nwr", wr_addr_q.size() - n0, 1);
        if (wr_addr_q.size() > n0) begin
            chk("glitch_after_addr", wr_addr_q[n0], 1);
            chk("glitch_after_val", {16'd0, wr_val_q[n0]}, 32'h7788);
        end

        // Randomized traffic against a plain element-list model.
        arm_pulse();
        m_addr = 0; m_hi_v = 0; m_done = 0; m_hi = '0;
        n0 = wr_addr_q.size();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                arm_pulse();
                m_addr = 0; m_hi_v = 0; m_done = 0;
            end else begin
                rb    = 8'($urandom);
                rstop = ($urandom_range(0, 9) != 0);
                f0    = ferr_cnt;
                send_byte(rb, rstop);
                if (!rstop) begin
                    m_hi_v = 0;
                end else if (!m_done) begin
                    if (!m_hi_v) begin
                        m_hi = rb; m_hi_v = 1;
                    end else begin
                        ex_a.push_back(32'(m_addr));
                        ex_v.push_back({m_hi, rb});
                        m_hi_v = 0;
                        m_addr++;
                        if (m_addr == N) m_done = 1;
                    end
                end
                chk($sformatf("rnd%0d_ferr", it), ferr_cnt - f0, {31'd0, !rstop});
            end
            chk($sformatf("rnd%0d_done", it), {31'd0, load_done}, {31'd0, m_done});
        end
        chk("rnd_nwr", wr_addr_q.size() - n0, ex_a.size());
        foreach (ex_a[k]) begin
            if (n0 + k < wr_addr_q.size()) begin
                chk($sformatf("rnd_w%0d_addr", k), wr_addr_q[n0 + k], ex_a[k]);
                chk($sformatf("rnd_w%0d_val", k), {16'd0, wr_val_q[n0 + k]}, {16'd0, ex_v[k]});
            end
        end

        // Reset in the middle of a load and of a frame.
        arm_pulse();
        send_byte(8'h5A, 1'b1);
        n0 = wr_addr_q.size();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst = 1'b1;
        rx_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_write", {31'd0, mem.write}, 0);
        chk("midrst_addr", mem.write_address, 0);
        chk("midrst_value", {16'd0, mem.write_value}, 0);
        chk("midrst_done", {31'd0, load_done}, 0);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        chk("postrst_nwr", wr_addr_q.size() - n0, 0);
        chk("postrst_ferr", {31'd0, frame_err}, 0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        chk("postrst_noarm_nwr", wr_addr_q.size() - n0, 0);
        arm_pulse();
        send_byte(8'h13, 1'b1);
        send_byte(8'h57, 1'b1);
        chk("postrst_arm_nwr", wr_addr_q.size() - n0, 1);
        if (wr_addr_q.size() > n0) begin
            chk("postrst_arm_addr", wr_addr_q[n0], 0);
            chk("postrst_arm_val", {16'd0, wr_val_q[n0]}, 32'h1357);
        end

        chk("write_one_cycle", wide_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
